// File: rtl/sync_memory.sv
// Single-port synchronous RAM with 1-cycle registered read and width-extending writes.
// Define SYNC_MEMORY_CLEAR_EN to compile in the clr-triggered / reset-triggered zero sweep.
module sync_memory #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int IN_W     = 8,
    parameter int SIGN_EXT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [IN_W-1:0]   din,
    input  logic              clr,
    output logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] ext;
    logic              acc;

    always_comb begin
        if (SIGN_EXT != 0) ext = DATA_W'($signed(din));
        else               ext = DATA_W'(din);
    end

`ifdef SYNC_MEMORY_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              clear_wr;

    // ready is registered alongside state so it drops on the same edge CLEAR is entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == '1) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign acc      = req && ready && !clr && rst_n;
    assign clear_wr = (state == CLEAR) && rst_n;

    always_ff @(posedge clk) begin
        if (clear_wr)      mem[cnt]  <= '0;
        else if (acc && we) mem[addr] <= ext;
    end
`else
    logic unused_clr;

    assign unused_clr = clr;
    assign ready      = 1'b1;
    assign acc        = req && rst_n;

    always_ff @(posedge clk) begin
        if (acc && we) mem[addr] <= ext;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (acc) begin
            if (we) begin
                dout       <= '0;
                dout_valid <= 1'b0;
            end else begin
                dout       <= mem[addr];
                dout_valid <= 1'b1;
            end
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_memory.sv
// Self-checking bench for sync_memory: default instance and a SIGN_EXT=1, ADDR_W=4 instance
// share stimulus; each is compared every cycle against an array-based reference model.
module tb_sync_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [7:0]  din = '0;
    logic        clr = 1'b0;
    logic        rdy0, rdy1, v0, v1;
    logic [15:0] dout0, dout1;

    int tests = 0;
    int fails = 0;

`ifdef SYNC_MEMORY_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    sync_memory u0 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .din(din),
        .clr(clr), .ready(rdy0), .dout(dout0), .dout_valid(v0)
    );

    sync_memory #(.ADDR_W(4), .SIGN_EXT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr[3:0]), .din(din),
        .clr(clr), .ready(rdy1), .dout(dout1), .dout_valid(v1)
    );

    // Reference model: index 0 = default instance, index 1 = sign-extending 16-word instance
    logic [15:0] mm [2][256];
    int          left [2] = '{0, 0};
    int          depth [2] = '{256, 16};
    logic [15:0] ed [2] = '{16'h0, 16'h0};
    logic        ev [2] = '{1'b0, 1'b0};

    function automatic logic [15:0] extend(input int k, input logic [7:0] d);
        int v;
        v = int'(d);
        if (k == 1 && v >= 128) v = v + 65280;
        return 16'(v);
    endfunction

    task automatic model_edge();
        int a;
        for (int k = 0; k < 2; k++) begin
            a = int'(addr) % depth[k];
            if (!rst_n) begin
                ed[k] = 16'h0;
                ev[k] = 1'b0;
                if (CLR_EN) left[k] = depth[k];
            end else if (left[k] > 0) begin
                mm[k][depth[k] - left[k]] = 16'h0;
                left[k] = left[k] - 1;
                ev[k] = 1'b0;
            end else if (CLR_EN && clr) begin
                left[k] = depth[k];
                ev[k] = 1'b0;
            end else if (req && we) begin
                mm[k][a] = extend(k, din);
                ed[k] = 16'h0;
                ev[k] = 1'b0;
            end else if (req) begin
                ed[k] = mm[k][a];
                ev[k] = 1'b1;
            end else begin
                ev[k] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic c, input logic rn);
        req = r; we = w; addr = a; din = d; clr = c; rst_n = rn;
        @(posedge clk);
        model_edge();
        #1;
        chk("u0.ready", {15'h0, rdy0}, {15'h0, left[0] == 0});
        chk("u0.dout_valid", {15'h0, v0}, {15'h0, ev[0]});
        chk("u0.dout", dout0, ed[0]);
        chk("u1.ready", {15'h0, rdy1}, {15'h0, left[1] == 0});
        chk("u1.dout_valid", {15'h0, v1}, {15'h0, ev[1]});
        chk("u1.dout", dout1, ed[1]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) mm[k][i] = 16'h0;

        // reset, then release (with the clear build, sweep-length ready checks)
        repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        idle(CLR_EN ? 260 : 2);

        // preload every location
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 8'(i), 8'($urandom), 1'b0, 1'b1);

        // directed: write then read, sign/zero extension, back-to-back reads
        step(1'b1, 1'b1, 8'h05, 8'hA7, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h10, 8'h80, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h10, 8'h7F, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h00, 8'h11, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h01, 8'h22, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h02, 8'h33, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b1);
        idle(1);

        // reset during a read, then confirm contents survived
        step(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0);
        idle(CLR_EN ? 260 : 1);
        step(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1);
        idle(1);

        // randomized traffic; clr is rare so clears do not dominate
        for (int i = 0; i < 2000; i++)
            step(($urandom % 4) != 0, 1'($urandom), 8'($urandom), 8'($urandom),
                 CLR_EN ? (($urandom % 128) == 0) : 1'($urandom), 1'b1);
        idle(CLR_EN ? 260 : 1);

        if (CLR_EN) begin
            // fill 0xFF, clr with simultaneous read, sweep, then read everything back
            for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 8'(i), 8'hFF, 1'b0, 1'b1);
            step(1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b1);
            idle(260);
            for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 8'(i), 8'h00, 1'b0, 1'b1);
            // reset at sweep count 100 restarts the full sweep
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
            idle(100);
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            idle(260);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_memory.md
SYNC_MEMORY -- requirements
Module: sync_memory

Interface
REQ-001 Parameter DATA_W, default 16: stored word width in bits.
REQ-002 Parameter ADDR_W, default 8: address width; depth is 2^ADDR_W words.
REQ-003 Parameter IN_W, default 8: write-data width; IN_W <= DATA_W.
REQ-004 Parameter SIGN_EXT, default 0: 0 zero-extends din to DATA_W, 1 sign-extends from din[IN_W-1].
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req  input  1  operation request, qualified by ready.
REQ-008 we  input  1  1 = write, 0 = read; sampled with req.
REQ-009 addr  input  ADDR_W  word address.
REQ-010 din  input  IN_W  write data.
REQ-011 clr  input  1  single-cycle pulse that requests a full-array clear.
REQ-012 ready  output  1  block accepts req this cycle.
REQ-013 dout  output  DATA_W  registered read data.
REQ-014 dout_valid  output  1  dout holds read data from the previous accepted read.

Function
REQ-015 The block SHALL accept an operation only on a rising edge where req && ready; req while ready=0 SHALL be ignored, with no queuing.
REQ-016 An accepted write SHALL set mem[addr] to ext(din) at that edge, where ext is a zero- or sign-extension per SIGN_EXT.
REQ-017 An accepted write SHALL drive dout=0 and dout_valid=0 in the following cycle.
REQ-018 An accepted read SHALL present mem[addr] on dout with dout_valid=1 in the following cycle; latency is exactly 1 cycle.
REQ-019 Back-to-back accepted reads SHALL sustain one result per cycle, with dout_valid held high.
REQ-020 A read accepted the cycle after a write to the same address SHALL return the newly written value.
REQ-021 In a cycle with no accepted operation, dout_valid SHALL be 0 and dout SHALL hold its last value.
REQ-022 The state machine SHALL have two states, IDLE and CLEAR; ready SHALL be 1 only in IDLE.
REQ-023 In CLEAR, a counter SHALL write 0 to address cnt each cycle, from 0 up to 2^ADDR_W-1.
REQ-024 After writing the last address, CLEAR SHALL go to IDLE, so a clear lasts exactly 2^ADDR_W cycles.
REQ-025 When clr=1 in IDLE, the block SHALL enter CLEAR at the next edge, and clr SHALL win over a simultaneous req.
REQ-026 clr SHALL be ignored while in CLEAR; the sweep does not restart.
REQ-027 The clear counter SHALL be ADDR_W bits wide, and its terminal count SHALL be detected without an overflow bit.

Reset
REQ-028 While rst_n=0 at an edge, the block SHALL set dout=0 and dout_valid=0 and reset the clear counter to 0.
REQ-029 With SYNC_MEMORY_CLEAR_EN defined, reset SHALL enter CLEAR, so ready=0 until the sweep completes.
REQ-030 With SYNC_MEMORY_CLEAR_EN undefined, reset SHALL enter IDLE, and ready SHALL be 1 in the first cycle after rst_n rises.
REQ-031 Reset asserted mid-clear SHALL restart the sweep from address 0 once rst_n rises.
REQ-032 Reset asserted mid-read SHALL suppress the pending dout_valid.
REQ-033 Memory contents SHALL be unaffected by reset, except through the clear sweep.

Configuration
REQ-034 Macro SYNC_MEMORY_CLEAR_EN SHALL select whether the clear feature is compiled in.
REQ-035 When SYNC_MEMORY_CLEAR_EN is defined, the CLEAR state, the counter and the clr input SHALL be active per REQ-022..027 and REQ-029.
REQ-036 When SYNC_MEMORY_CLEAR_EN is undefined, the CLEAR state and the counter SHALL not exist.
REQ-037 When SYNC_MEMORY_CLEAR_EN is undefined, clr SHALL be ignored, ready SHALL be tied to 1 out of reset, and memory SHALL be uninitialised.

Verification
REQ-038 Default params: write addr 0x05 din 0xA7, then read 0x05 -> next cycle dout=0x00A7 and dout_valid=1; write cycle gives dout=0 and dout_valid=0.
REQ-039 SIGN_EXT=1: write addr 0x10 din 0x80, then read -> dout=0xFF80; din 0x7F -> dout=0x007F.
REQ-040 Reads of 0x00, 0x01, 0x02 on consecutive cycles, preloaded 0x11, 0x22, 0x33 -> dout 0x0011, 0x0022, 0x0033 on consecutive cycles with dout_valid held 1.
REQ-041 CLEAR_EN defined, ADDR_W=4: release rst_n -> ready=0 for exactly 16 cycles; then reads of all 16 addresses return 0.
REQ-042 CLEAR_EN defined: fill 0xFF, pulse clr with a simultaneous read req -> read dropped, 256-cycle clear runs, all locations read 0.
REQ-043 CLEAR_EN defined: assert rst_n=0 at sweep count 100 -> after release, ready=0 for a full 256 cycles.
